gabor_win_sched: RTL and testbench
==================================

Name: gabor_win_sched

Overview:
- Sequencer between the 256x32 image memory and the Gabor filter MAC core.
- Raster-walks every pixel of the stored image.
- For each pixel, fetches its 3x3 neighbourhood from the memory's combinational read port, with zero padding at the borders.
- Streams the 9 taps to the filter core over a valid/ready handshake, waits for the filtered result, and writes it to the output buffer.

Parameters:
- IMG_W, 16, image width in pixels.
- IMG_H, 16, image height in pixels; IMG_W*IMG_H must not exceed 2**ADDR_W.
- ADDR_W, 8, memory address width.
- DATA_W, 32, pixel/result word width.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one full-image pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at the end of a pass.
- rd_addr  out  ADDR_W  drives the image memory read_address (combinational read).
- rd_data  in  DATA_W  image memory read_data, valid in the same cycle.
- tap_data  out  DATA_W  pixel tap to the filter (registered).
- tap_idx  out  4  tap number 0..8, row-major over dy,dx in {-1,0,+1}.
- tap_valid  out  1  tap_data/tap_idx valid.
- tap_last  out  1  high with tap_idx==8.
- tap_ready  in  1  filter accepts the tap when tap_valid&tap_ready.
- res_data  in  DATA_W  filtered pixel result.
- res_valid  in  1  one-cycle result strobe.
- wr_addr  out  ADDR_W  output buffer write address (= pixel index y*IMG_W+x).
- wr_data  out  DATA_W  output buffer write data.
- wr_en  out  1  output buffer write enable, one cycle per pixel.

Behaviour:
- Reset (rst=1 at a clock edge, at any time, including mid-pass):
  - State=IDLE; x=y=tap=0.
  - busy, done, tap_valid, tap_last, wr_en = 0.
  - tap_data, tap_idx, wr_addr, wr_data, rd_addr = 0.
  - Any in-flight tap or result is discarded.
- States: IDLE, FETCH, WAIT_RES, WRITE, DONE.
- IDLE:
  - start=1 -> FETCH with x=y=tap=0; busy goes high next cycle.
  - start in any other state is ignored.
- FETCH:
  - Neighbour coordinates: nx=x+(tap%3)-1, ny=y+(tap/3)-1.
  - rd_addr=ny*IMG_W+nx combinationally when in range, else rd_addr holds 0.
  - Load condition: (!tap_valid || tap_ready). When true, register:
    - tap_data = rd_data if in range, else 0;
    - tap_idx = tap; tap_last = (tap==8); tap_valid = 1; tap += 1.
  - Address-to-tap latency is one cycle. With tap_ready held high, taps issue back-to-back, 9 cycles per pixel.
  - The accept of the tap_last beat (tap_valid&tap_ready&tap_last) clears tap_valid -> WAIT_RES.
  - tap_valid never drops while tap_ready=0. tap_data/tap_idx are stable until accepted.
- WAIT_RES:
  - res_valid=1 -> register wr_data=res_data, wr_addr=y*IMG_W+x, wr_en=1 -> WRITE.
  - res_valid outside WAIT_RES is ignored, with no write.
- WRITE:
  - wr_en drops next cycle.
  - If x==IMG_W-1 and y==IMG_H-1 -> DONE.
  - Otherwise advance x, wrapping to 0 with y+1 at IMG_W-1; tap=0; -> FETCH.
- DONE: done=1 for one cycle, busy=0 next cycle -> IDLE.
- Padding: nx<0, nx>=IMG_W, ny<0 or ny>=IMG_H gives tap value 0. Corner pixels get 5 zero taps; edge pixels get 3.
- Arithmetic: nx and ny are computed signed, one bit wider than the coordinate counters, to detect -1 without wrap. Address products are truncated to ADDR_W.

Decomposition:
- Package gabor_pkg holds:
  - state enum (IDLE, FETCH, WAIT_RES, WRITE, DONE);
  - constants KSIZE=3, TAP_N=9, TAP_W=4.
- One combinational sub-module, gabor_win_addr. Inputs: x, y, tap. Outputs: rd_addr, in_range. It holds all padding and address math so it can be unit-tested alone.

Test Plan:
- Reset mid-pass:
  - Stimulus: start, let 4 taps issue, then rst=1 for one cycle.
  - Required: all outputs 0 next cycle, state IDLE. A new start re-fetches pixel 0 from tap 0.
- Interior pixel, IMG_W=IMG_H=4, memory[i]=i, tap_ready=1:
  - Pixel (1,1) taps are 0,1,2,4,5,6,8,9,10, consecutive cycles, tap_last on 10.
- Corner padding:
  - Pixel (0,0) taps are 0,0,0,0,0,1,0,4,5.
  - Pixel (3,3) taps are 10,11,0,14,15,0,0,0,0.
- Backpressure:
  - Stimulus: tap_ready toggled 1,0,0,1 pattern.
  - Required: tap_data/tap_idx stable while stalled; no tap lost or duplicated (exactly 9 accepts per pixel).
- Result write-back:
  - Stimulus: res_valid asserted 3 cycles after tap_last with res_data=32'hA5A5_0005 at pixel 5.
  - Required: wr_en for exactly one cycle with wr_addr=5, wr_data=32'hA5A5_0005. A spurious res_valid during FETCH produces no write.
- Full pass 4x4:
  - Stimulus: filter model returns the tap sum.
  - Required: 16 writes at addresses 0..15 in order, done pulse once, busy low after. A start during busy is ignored.

Source files
------------

// File: rtl/gabor_pkg.sv
// Shared definitions for the Gabor window scheduler.
//   state_t  : sequencer states
//   KSIZE    : kernel edge length (3x3 window)
//   TAP_N    : taps per pixel
//   TAP_W    : width of the tap counter / tap index
//   tap_col / tap_row : column and row (0..2) of a tap inside the window
package gabor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RES,
    WRITE,
    DONE
  } state_t;

  localparam int KSIZE = 3;
  localparam int TAP_N = 9;
  localparam int TAP_W = 4;

  // Lookup rather than tap % 3 keeps the logic shallow.
  // Out-of-window tap numbers map to 0; callers mask them separately.
  function automatic logic [1:0] tap_col(input logic [TAP_W-1:0] tap);
    logic [1:0] c;
    c = 2'd0;
    case (tap)
      4'd1, 4'd4, 4'd7: c = 2'd1;
      4'd2, 4'd5, 4'd8: c = 2'd2;
      default:          c = 2'd0;
    endcase
    return c;
  endfunction

  // Lookup rather than tap / 3.
  function automatic logic [1:0] tap_row(input logic [TAP_W-1:0] tap);
    logic [1:0] r;
    r = 2'd0;
    case (tap)
      4'd3, 4'd4, 4'd5: r = 2'd1;
      4'd6, 4'd7, 4'd8: r = 2'd2;
      default:          r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gabor_win_addr.sv
// Neighbour address generator for one 3x3 window tap.
// Ports:
//   x, y      : centre pixel coordinates
//   tap       : tap number 0..8, row-major over dy,dx in {-1,0,+1}
//   rd_addr   : linear address ny*IMG_W+nx, 0 when out of range
//   in_range  : neighbour lies inside the image (and tap < TAP_N)
// Purely combinational.
module gabor_win_addr
  import gabor_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8,
  parameter int X_W    = 5,
  parameter int Y_W    = 5
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [TAP_W-1:0]  tap,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              in_range
);

  localparam logic [X_W:0] W_LIM = (X_W+1)'(IMG_W);
  localparam logic [Y_W:0] H_LIM = (Y_W+1)'(IMG_H);

  logic [1:0]          col;
  logic [1:0]          row;
  // One bit wider and signed so that x-1 at x==0 reads as -1, not a wrap.
  logic signed [X_W:0] nx;
  logic signed [Y_W:0] ny;
  logic                x_ok;
  logic                y_ok;
  logic                tap_ok;

  assign col = tap_col(tap);
  assign row = tap_row(tap);

  assign nx = $signed({1'b0, x}) + $signed({{(X_W-1){1'b0}}, col}) - $signed((X_W+1)'(1));
  assign ny = $signed({1'b0, y}) + $signed({{(Y_W-1){1'b0}}, row}) - $signed((Y_W+1)'(1));

  assign x_ok   = !nx[X_W] && ($unsigned(nx) < W_LIM);
  assign y_ok   = !ny[Y_W] && ($unsigned(ny) < H_LIM);
  assign tap_ok = tap < TAP_W'(TAP_N);

  assign in_range = tap_ok && x_ok && y_ok;

  assign rd_addr = in_range
                 ? ADDR_W'(ny[Y_W-1:0]) * ADDR_W'(IMG_W) + ADDR_W'(nx[X_W-1:0])
                 : '0;

endmodule

// File: rtl/gabor_win_sched.sv
// Sequencer between the image memory and the Gabor filter MAC core.
// Walks every pixel in raster order, streams its zero-padded 3x3
// neighbourhood to the filter over valid/ready, waits for the result and
// writes it to the output buffer.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start / busy / done      : pass control and status
//   rd_addr / rd_data        : combinational image memory read port
//   tap_*                    : tap stream to the filter (valid/ready)
//   res_data / res_valid     : filtered result strobe from the filter
//   wr_addr / wr_data / wr_en: output buffer write port
module gabor_win_sched
  import gabor_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] tap_data,
  output logic [3:0]        tap_idx,
  output logic              tap_valid,
  output logic              tap_last,
  input  logic              tap_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en
);

  // Counters can hold IMG_W / IMG_H so neighbour math never overflows.
  localparam int X_W = $clog2(IMG_W + 1);
  localparam int Y_W = $clog2(IMG_H + 1);

  state_t            state_reg, state_next;
  logic [X_W-1:0]    x_reg, x_next;
  logic [Y_W-1:0]    y_reg, y_next;
  logic [TAP_W-1:0]  tap_reg, tap_next;
  logic [DATA_W-1:0] tap_data_reg, tap_data_next;
  logic [3:0]        tap_idx_reg, tap_idx_next;
  logic              tap_valid_reg, tap_valid_next;
  logic              tap_last_reg, tap_last_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic              wr_en_reg, wr_en_next;

  logic [ADDR_W-1:0] win_addr;
  logic              in_range;
  logic [ADDR_W-1:0] pix_addr;

  gabor_win_addr #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_win_addr (
    .x        (x_reg),
    .y        (y_reg),
    .tap      (tap_reg),
    .rd_addr  (win_addr),
    .in_range (in_range)
  );

  assign pix_addr = ADDR_W'(y_reg) * ADDR_W'(IMG_W) + ADDR_W'(x_reg);

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    tap_next       = tap_reg;
    tap_data_next  = tap_data_reg;
    tap_idx_next   = tap_idx_reg;
    tap_valid_next = tap_valid_reg;
    tap_last_next  = tap_last_reg;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    wr_en_next     = wr_en_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          x_next     = '0;
          y_next     = '0;
          tap_next   = '0;
        end
      end

      FETCH: begin
        if (tap_valid_reg && tap_ready && tap_last_reg) begin
          // Last beat accepted: nothing left to load for this pixel.
          tap_valid_next = 1'b0;
          tap_last_next  = 1'b0;
          state_next     = WAIT_RES;
        end else if ((tap_reg < TAP_W'(TAP_N)) && (!tap_valid_reg || tap_ready)) begin
          tap_data_next  = in_range ? rd_data : '0;
          tap_idx_next   = 4'(tap_reg);
          tap_last_next  = (tap_reg == TAP_W'(TAP_N - 1));
          tap_valid_next = 1'b1;
          tap_next       = tap_reg + TAP_W'(1);
        end
      end

      WAIT_RES: begin
        if (res_valid) begin
          wr_data_next = res_data;
          wr_addr_next = pix_addr;
          wr_en_next   = 1'b1;
          state_next   = WRITE;
        end
      end

      WRITE: begin
        wr_en_next = 1'b0;
        if (x_reg == X_W'(IMG_W - 1) && y_reg == Y_W'(IMG_H - 1)) begin
          state_next = DONE;
        end else begin
          if (x_reg == X_W'(IMG_W - 1)) begin
            x_next = '0;
            y_next = y_reg + Y_W'(1);
          end else begin
            x_next = x_reg + X_W'(1);
          end
          tap_next   = '0;
          state_next = FETCH;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      tap_reg       <= '0;
      tap_data_reg  <= '0;
      tap_idx_reg   <= '0;
      tap_valid_reg <= 1'b0;
      tap_last_reg  <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      wr_en_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      tap_reg       <= tap_next;
      tap_data_reg  <= tap_data_next;
      tap_idx_reg   <= tap_idx_next;
      tap_valid_reg <= tap_valid_next;
      tap_last_reg  <= tap_last_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      wr_en_reg     <= wr_en_next;
    end
  end

  // busy rises the cycle after start is taken and falls the cycle after DONE.
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign rd_addr   = (state_reg == FETCH) ? win_addr : '0;
  assign tap_data  = tap_data_reg;
  assign tap_idx   = tap_idx_reg;
  assign tap_valid = tap_valid_reg;
  assign tap_last  = tap_last_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign wr_en     = wr_en_reg;

endmodule

// File: tb/tb_gabor_win_sched.sv
// Randomized, model-checked bench for gabor_win_sched on a 4x4 image.
module tb_gabor_win_sched;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] tap_data;
  logic [3:0]    tap_idx;
  logic          tap_valid, tap_last;
  logic          tap_ready = 1'b1;
  logic [DW-1:0] res_data  = '0;
  logic          res_valid = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;

  logic [DW-1:0] mem [256];
  assign rd_data = mem[rd_addr];

  gabor_win_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .tap_data(tap_data), .tap_idx(tap_idx), .tap_valid(tap_valid),
    .tap_last(tap_last), .tap_ready(tap_ready),
    .res_data(res_data), .res_valid(res_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected tap value straight from the window definition.
  function automatic logic [31:0] exp_tap(input int pix, input int t);
    int x, y, nx, ny;
    x  = pix % W;
    y  = pix / W;
    nx = x + (t % 3) - 1;
    ny = y + (t / 3) - 1;
    if (nx < 0 || nx >= W || ny < 0 || ny >= H) return 32'd0;
    return mem[ny * W + nx];
  endfunction

  // Control shared with the stimulus process (written only there).
  int ready_mode = 0;   // 0 always ready, 1 pattern 1,0,0,1, 2 random
  bit spur_en    = 1'b0;
  bit cap_en     = 1'b0;

  // Model / scoreboard state (written only by the monitor process).
  int cur_pix = 0, cur_tap = 0, wr_idx = 0, done_cnt = 0, acc_total = 0;
  int res_cnt = 0, res_pix = 0, first_cyc = 0, cyc = 0, pat_i = 0;
  logic [31:0] tap_sum = '0;
  logic [31:0] res_of [NPIX];
  logic [31:0] cap0 [9], cap5 [9], cap15 [9];
  bit rst_prev = 1'b0, prev_stall = 1'b0, prev_wr = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [3:0]    prev_idx  = '0;

  // Monitor + filter model: drives tap_ready/res_valid and checks outputs,
  // all on the falling edge so the DUT sees stable inputs at posedge.
  always @(negedge clk) begin
    cyc++;
    res_valid = 1'b0;
    res_data  = '0;
    case (ready_mode)
      0:       tap_ready = 1'b1;
      1:       begin tap_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3); pat_i++; end
      default: tap_ready = 1'($urandom_range(0, 1));
    endcase

    if (rst_prev) begin
      check("rst_ctrl", {27'd0, busy, done, tap_valid, tap_last, wr_en}, 32'd0);
      check("rst_tap_data", tap_data, 32'd0);
      check("rst_idx_wraddr", {20'd0, tap_idx, wr_addr}, 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_rd_addr", {24'd0, rd_addr}, 32'd0);
    end

    if (rst) begin
      rst_prev = 1'b1;
      cur_pix = 0; cur_tap = 0; wr_idx = 0; done_cnt = 0; res_cnt = 0;
      tap_sum = '0; pat_i = 0; prev_stall = 1'b0; prev_wr = 1'b0;
    end else begin
      rst_prev = 1'b0;
      if (prev_stall)
        check("stall_hold", {tap_valid, tap_idx, tap_data[26:0]}, {1'b1, prev_idx, prev_data[26:0]});

      if (res_cnt > 0) begin
        res_cnt--;
        if (res_cnt == 0) begin
          res_valid = 1'b1;
          res_data  = res_of[res_pix];
        end
      end else if (spur_en && tap_valid && $urandom_range(0, 5) == 0) begin
        res_valid = 1'b1;           // filter glitch during FETCH; must be ignored
        res_data  = 32'hDEAD_BEEF;
      end

      if (tap_valid && tap_ready) begin
        check("tap_data", tap_data, exp_tap(cur_pix, cur_tap));
        check("tap_idx", {28'd0, tap_idx}, cur_tap);
        check("tap_last", {31'd0, tap_last}, {31'd0, cur_tap == 8});
        if (cap_en && cur_pix == 0)  cap0[cur_tap]  = tap_data;
        if (cap_en && cur_pix == 5)  cap5[cur_tap]  = tap_data;
        if (cap_en && cur_pix == 15) cap15[cur_tap] = tap_data;
        tap_sum += tap_data;
        if (cur_tap == 0) first_cyc = cyc;
        if (cur_tap == 8) begin
          if (ready_mode == 0) check("burst_len", cyc - first_cyc, 32'd8);
          res_pix = cur_pix;
          res_of[cur_pix] = (cur_pix == 5 && ready_mode == 0) ? 32'hA5A5_0005 : tap_sum;
          res_cnt = (cur_pix == 5) ? 3 : int'($urandom_range(1, 4));
          tap_sum = '0;
          cur_tap = 0;
          cur_pix++;
        end else begin
          cur_tap++;
        end
        acc_total++;
      end
      prev_stall = tap_valid && !tap_ready;
      prev_data  = tap_data;
      prev_idx   = tap_idx;

      if (wr_en) begin
        check("wr_addr", {24'd0, wr_addr}, wr_idx);
        check("wr_data", wr_data, (wr_idx < NPIX) ? res_of[wr_idx] : 32'hFFFF_FFFF);
        check("wr_single", {31'd0, prev_wr}, 32'd0);
        if (ready_mode == 0 && wr_idx == 5) check("wr_px5", wr_data, 32'hA5A5_0005);
        wr_idx++;
      end
      prev_wr = wr_en;
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_pass(input int mode, input bit spur);
    int n;
    ready_mode = mode;
    spur_en    = spur;
    do_reset(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      start = (n == 40);           // start while busy: must be ignored
      tick();
      n++;
    end
    start = 1'b0;
    check("pass_timeout", {31'd0, done_cnt == 0}, 32'd0);
    repeat (4) tick();
    check("done_once", done_cnt, 32'd1);
    check("write_count", wr_idx, NPIX);
    check("pixel_count", cur_pix, NPIX);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("idle_no_tap", {31'd0, tap_valid}, 32'd0);
  endtask

  logic [31:0] lit0  [9] = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
  logic [31:0] lit5  [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  logic [31:0] lit15 [9] = '{10, 11, 0, 14, 15, 0, 0, 0, 0};

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = i;
    do_reset(3);

    for (int t = 0; t < 9; t++) begin
      check("model_px0", exp_tap(0, t), lit0[t]);
      check("model_px5", exp_tap(5, t), lit5[t]);
      check("model_px15", exp_tap(15, t), lit15[t]);
    end

    // Reset mid-pass after four accepted taps.
    ready_mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (acc_total < 4 && n < 100) begin tick(); n++; end
    check("four_tap_timeout", {31'd0, acc_total < 4}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("midrst_idle", {30'd0, busy, tap_valid}, 32'd0);

    // Pass 1: identity memory, always ready, pixel-5 result pinned.
    cap_en = 1'b1;
    run_pass(0, 1'b0);
    cap_en = 1'b0;
    for (int t = 0; t < 9; t++) begin
      check("dut_px0", cap0[t], lit0[t]);
      check("dut_px5", cap5[t], lit5[t]);
      check("dut_px15", cap15[t], lit15[t]);
    end

    // Pass 2: random image, ready pattern 1,0,0,1, spurious results.
    for (int i = 0; i < NPIX; i++) mem[i] = $urandom;
    run_pass(1, 1'b1);

    // Pass 3: random image, random ready, spurious results.
    for (int i = 0; i < NPIX; i++) mem[i] = $urandom;
    run_pass(2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
